scarv_mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-ported data memory between the host CPU data port and the COP memory port (`cop_mem_*`). It sits between those two masters and the memory. It grants ownership at transaction boundaries with round-robin fairness and a bounded back-to-back burst. Downstream never sees a request change while it is stalling.

---
 rtl/scarv_mem_arbiter_pkg.sv | 31 +++
 rtl/scarv_mem_arbiter_mux.sv | 34 +++
 rtl/scarv_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_scarv_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scarv_mem_arbiter_pkg.sv
`timescale 1ns/1ps
// Shared encodings and bus bundles for the CPU/COP data-memory arbiter.
// Owner codes double as FSM state codes, so arb_owner is the state register itself.
package scarv_mem_arbiter_pkg;

  localparam int SCARV_BURST_MAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    SCARV_ARB_NONE = 2'd0,
    SCARV_ARB_CPU  = 2'd1,
    SCARV_ARB_COP  = 2'd2
  } arb_owner_e;

  typedef struct packed {
    logic        cen;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        stall;
    logic        error;
  } mem_rsp_t;

  localparam mem_req_t MEM_REQ_IDLE    = '0;
  localparam mem_rsp_t MEM_RSP_BLOCKED = '{rdata: 32'd0, stall: 1'b1, error: 1'b0};

endpackage

// File: rtl/scarv_mem_arbiter_mux.sv
`timescale 1ns/1ps
// Combinational steering: forwards the owner's request downstream and returns the
// memory response to the owner only; everyone else sees a blocked, zeroed response.
module scarv_mem_arbiter_mux
  import scarv_mem_arbiter_pkg::*;
(
  input  arb_owner_e i_owner,
  input  mem_req_t   i_cpu_req,
  input  mem_req_t   i_cop_req,
  input  mem_rsp_t   i_mem_rsp,
  output mem_req_t   o_mem_req,
  output mem_rsp_t   o_cpu_rsp,
  output mem_rsp_t   o_cop_rsp
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    o_mem_req = MEM_REQ_IDLE;
    o_cpu_rsp = MEM_RSP_BLOCKED;
    o_cop_rsp = MEM_RSP_BLOCKED;
    case (i_owner)
      SCARV_ARB_CPU: begin
        o_mem_req = i_cpu_req;
        o_cpu_rsp = i_mem_rsp;
      end
      SCARV_ARB_COP: begin
        o_mem_req = i_cop_req;
        o_cop_rsp = i_mem_rsp;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/scarv_mem_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one single-ported data memory between the CPU data port
// and the COP memory port; ownership only moves at transaction boundaries.
module scarv_mem_arbiter
  import scarv_mem_arbiter_pkg::*;
#(
  parameter int BURST_MAX = SCARV_BURST_MAX_DEFAULT
) (
  input  logic        g_clk,
  input  logic        g_rst,
  input  logic        cpu_mem_cen,
  input  logic        cpu_mem_wen,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_ben,
  output logic [31:0] cpu_mem_rdata,
  output logic        cpu_mem_stall,
  output logic        cpu_mem_error,
  input  logic        cop_mem_cen,
  input  logic        cop_mem_wen,
  input  logic [31:0] cop_mem_addr,
  input  logic [31:0] cop_mem_wdata,
  input  logic [3:0]  cop_mem_ben,
  output logic [31:0] cop_mem_rdata,
  output logic        cop_mem_stall,
  output logic        cop_mem_error,
  output logic        mem_cen,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_ben,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall,
  input  logic        mem_error,
  output logic [1:0]  arb_owner
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  arb_owner_e       r_state;
  arb_owner_e       r_last;
  logic [CNT_W-1:0] r_cnt;

  mem_req_t   w_cpu_req, w_cop_req, w_mem_req;
  mem_rsp_t   w_mem_rsp, w_cpu_rsp, w_cop_rsp;
  arb_owner_e w_other;
  logic       w_own_cen, w_oth_cen, w_burst_done, w_cnt_sat;

  assign w_cpu_req = '{cen: cpu_mem_cen, wen: cpu_mem_wen, addr: cpu_mem_addr,
                       wdata: cpu_mem_wdata, ben: cpu_mem_ben};
  assign w_cop_req = '{cen: cop_mem_cen, wen: cop_mem_wen, addr: cop_mem_addr,
                       wdata: cop_mem_wdata, ben: cop_mem_ben};
  assign w_mem_rsp = '{rdata: mem_rdata, stall: mem_stall, error: mem_error};

  assign w_own_cen = (r_state == SCARV_ARB_CPU) ? cpu_mem_cen : cop_mem_cen;
  assign w_oth_cen = (r_state == SCARV_ARB_CPU) ? cop_mem_cen : cpu_mem_cen;
  assign w_other   = (r_state == SCARV_ARB_CPU) ? SCARV_ARB_COP : SCARV_ARB_CPU;

  // Once saturated the tenure has already used its whole burst, so a newly waiting
  // requester takes over at the next completion instead of being starved.
  assign w_burst_done = (r_cnt >= CNT_W'(BURST_MAX - 1));
  assign w_cnt_sat    = (r_cnt == CNT_W'(BURST_MAX));

  always_ff @(posedge g_clk or posedge g_rst) begin
    // NOTE: state is sequential, so non-blocking assignments keep every read in this
    // block seeing the pre-edge values regardless of statement order.
    if (g_rst) begin
      r_state <= SCARV_ARB_NONE;
      r_last  <= SCARV_ARB_COP;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        SCARV_ARB_NONE: begin
          r_cnt <= '0;
          if (cpu_mem_cen && (!cop_mem_cen || r_last == SCARV_ARB_COP)) r_state <= SCARV_ARB_CPU;
          else if (cop_mem_cen)                                         r_state <= SCARV_ARB_COP;
        end
        SCARV_ARB_CPU, SCARV_ARB_COP: begin
          if (!w_own_cen) begin
            r_last  <= r_state;
            r_cnt   <= '0;
            r_state <= w_oth_cen ? w_other : SCARV_ARB_NONE;
          end else if (!mem_stall) begin
            if (w_burst_done && w_oth_cen) begin
              r_last  <= r_state;
              r_cnt   <= '0;
              r_state <= w_other;
            end else if (!w_cnt_sat) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= SCARV_ARB_NONE;
      endcase
    end
  end

  scarv_mem_arbiter_mux u_mux (
    .i_owner   (r_state),
    .i_cpu_req (w_cpu_req),
    .i_cop_req (w_cop_req),
    .i_mem_rsp (w_mem_rsp),
    .o_mem_req (w_mem_req),
    .o_cpu_rsp (w_cpu_rsp),
    .o_cop_rsp (w_cop_rsp)
  );

  assign mem_cen       = w_mem_req.cen;
  assign mem_wen       = w_mem_req.wen;
  assign mem_addr      = w_mem_req.addr;
  assign mem_wdata     = w_mem_req.wdata;
  assign mem_ben       = w_mem_req.ben;
  assign cpu_mem_rdata = w_cpu_rsp.rdata;
  assign cpu_mem_stall = w_cpu_rsp.stall;
  assign cpu_mem_error = w_cpu_rsp.error;
  assign cop_mem_rdata = w_cop_rsp.rdata;
  assign cop_mem_stall = w_cop_rsp.stall;
  assign cop_mem_error = w_cop_rsp.error;
  assign arb_owner     = r_state;

endmodule

// File: tb/tb_scarv_mem_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for scarv_mem_arbiter: directed scenarios plus randomized traffic,
// checked against a tenure/round-robin reference model and per-requester queues.
module tb_scarv_mem_arbiter;

  localparam int BURST = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        g_clk = 1'b0;
  logic        g_rst;
  logic        rq_cen [2];
  logic        rq_wen [2];
  logic [31:0] rq_addr [2];
  logic [31:0] rq_wdata [2];
  logic [3:0]  rq_ben [2];
  logic [31:0] rs_rdata [2];
  logic        rs_stall [2];
  logic        rs_error [2];
  logic        mem_cen, mem_wen, mem_stall, mem_error;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_ben;
  logic [1:0]  arb_owner;

  int n_checks = 0;
  int n_errors = 0;

  exp_t cpu_q[$];
  exp_t cop_q[$];
  int   log_who[$];
  int   log_cyc[$];
  int   cyc = 0;

  int          iss_pct [2];
  int          iss_left [2];
  logic        active [2];
  logic [31:0] fixed_addr [2];
  int          done_cnt [2];
  int          retired [2];
  int          stall_pct;
  int          stall_force;

  int m_owner, m_last, m_cnt;

  scarv_mem_arbiter dut (
    .g_clk         (g_clk),
    .g_rst         (g_rst),
    .cpu_mem_cen   (rq_cen[0]),
    .cpu_mem_wen   (rq_wen[0]),
    .cpu_mem_addr  (rq_addr[0]),
    .cpu_mem_wdata (rq_wdata[0]),
    .cpu_mem_ben   (rq_ben[0]),
    .cpu_mem_rdata (rs_rdata[0]),
    .cpu_mem_stall (rs_stall[0]),
    .cpu_mem_error (rs_error[0]),
    .cop_mem_cen   (rq_cen[1]),
    .cop_mem_wen   (rq_wen[1]),
    .cop_mem_addr  (rq_addr[1]),
    .cop_mem_wdata (rq_wdata[1]),
    .cop_mem_ben   (rq_ben[1]),
    .cop_mem_rdata (rs_rdata[1]),
    .cop_mem_stall (rs_stall[1]),
    .cop_mem_error (rs_error[1]),
    .mem_cen       (mem_cen),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ben       (mem_ben),
    .mem_rdata     (mem_rdata),
    .mem_stall     (mem_stall),
    .mem_error     (mem_error),
    .arb_owner     (arb_owner)
  );

  always #5 g_clk = ~g_clk;

  // Memory responder: read data and error are fixed functions of the address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : ((a ^ 32'hC0DE_0000) + 32'h1357);
  endfunction

  function automatic logic errf(input logic [31:0] a);
    return a[5:2] == 4'hF;
  endfunction

  assign mem_rdata = rom(mem_addr);
  assign mem_error = mem_cen && errf(mem_addr);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one owner at a time, round-robin on ties, owner keeps the grant
  // until it stops requesting or has finished BURST transactions while the other waits.
  task automatic model_step();
    bit want [3];
    int x, y;
    want[0] = 1'b0;
    want[1] = rq_cen[0];
    want[2] = rq_cen[1];
    if (m_owner == 0) begin
      if (want[1] && want[2]) m_owner = (m_last == 1) ? 2 : 1;
      else if (want[1])       m_owner = 1;
      else if (want[2])       m_owner = 2;
      m_cnt = 0;
    end else begin
      x = m_owner;
      y = 3 - x;
      if (!want[x]) begin
        m_last  = x;
        m_owner = want[y] ? y : 0;
        m_cnt   = 0;
      end else if (!mem_stall) begin
        m_cnt++;
        if (m_cnt >= BURST && want[y]) begin
          m_last  = x;
          m_owner = y;
          m_cnt   = 0;
        end else if (m_cnt > BURST) begin
          m_cnt = BURST;
        end
      end
    end
  endtask

  // Monitor: mid-cycle comparison of every port against the model and the queues.
  always @(negedge g_clk) begin
    if (g_rst) begin
      m_owner = 0;
      m_last  = 2;
      m_cnt   = 0;
    end else begin
      exp_t e;
      check("owner", arb_owner, m_owner);
      if (m_owner == 0) check("idle_mem_cen", mem_cen, 0);
      for (int r = 0; r < 2; r++) begin
        if (m_owner == r + 1) begin
          check("fwd_req", {mem_cen, mem_wen, mem_addr, mem_wdata, mem_ben},
                {rq_cen[r], rq_wen[r], rq_addr[r], rq_wdata[r], rq_ben[r]});
          check("fwd_stall", rs_stall[r], mem_stall);
        end else begin
          check("blocked_rsp", {rs_stall[r], rs_error[r], rs_rdata[r]}, {1'b1, 1'b0, 32'd0});
        end
        if (rq_cen[r] && !rs_stall[r]) begin
          if (r == 0 && cpu_q.size() > 0) begin
            e = cpu_q.pop_front();
            check("cpu_rsp", {rs_error[r], rs_rdata[r]}, {e.err, e.rdata});
          end else if (r == 1 && cop_q.size() > 0) begin
            e = cop_q.pop_front();
            check("cop_rsp", {rs_error[r], rs_rdata[r]}, {e.err, e.rdata});
          end else begin
            check("extra_completion", 0, 1);
          end
          log_who.push_back(r + 1);
          log_cyc.push_back(cyc);
          done_cnt[r]++;
        end
      end
      model_step();
    end
    cyc++;
  end

  task automatic issue(input int r);
    exp_t e;
    if (fixed_addr[r] != 32'd0) begin
      rq_addr[r]    = fixed_addr[r];
      rq_wen[r]     = 1'b0;
      fixed_addr[r] = 32'd0;
    end else begin
      rq_addr[r] = $urandom() & 32'hFFFF_FFFC;
      rq_wen[r]  = 1'($urandom_range(1));
    end
    rq_wdata[r] = $urandom();
    rq_ben[r]   = 4'($urandom_range(15));
    active[r]   = 1'b1;
    iss_left[r]--;
    e.rdata = rom(rq_addr[r]);
    e.err   = errf(rq_addr[r]);
    if (r == 0) cpu_q.push_back(e);
    else        cop_q.push_back(e);
  endtask

  task automatic drive_cycle();
    for (int r = 0; r < 2; r++) begin
      if (done_cnt[r] != retired[r]) begin
        retired[r]++;
        active[r] = 1'b0;
      end
      if (!active[r] && iss_left[r] > 0 && $urandom_range(99) < iss_pct[r]) issue(r);
      rq_cen[r] = active[r];
    end
    if (stall_force > 0 && arb_owner != 2'd0) begin
      mem_stall = 1'b1;
      stall_force--;
    end else begin
      mem_stall = ($urandom_range(99) < stall_pct);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
    drive_cycle();
    #3;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((active[0] || active[1]) && n < budget) begin
      step();
      n++;
    end
    check("drain", {active[0], active[1]}, 2'b00);
    repeat (3) step();
  endtask

  initial begin
    int base, n;
    g_rst = 1'b1;
    mem_stall = 1'b0;
    stall_pct = 0;
    stall_force = 0;
    for (int r = 0; r < 2; r++) begin
      rq_cen[r] = 1'b0; rq_wen[r] = 1'b0; rq_addr[r] = '0; rq_wdata[r] = '0; rq_ben[r] = '0;
      iss_pct[r] = 100; iss_left[r] = 0; active[r] = 1'b0; fixed_addr[r] = '0;
      done_cnt[r] = 0; retired[r] = 0;
    end
    repeat (3) @(posedge g_clk);
    #4;
    check("reset_mem", {mem_cen, mem_wen, mem_addr, mem_wdata, mem_ben}, '0);
    check("reset_rsp", {rs_stall[0], rs_error[0], rs_rdata[0], rs_stall[1], rs_error[1], rs_rdata[1]},
          {1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0});
    check("reset_owner", arb_owner, 0);
    @(posedge g_clk);
    #1 g_rst = 1'b0;

    // First tie after reset goes to the CPU.
    iss_left[0] = 1; iss_left[1] = 1;
    step(); check("tie1_c0", arb_owner, 0);
    step(); check("tie1_c1", arb_owner, 1); check("tie1_cop_wait", rs_stall[1], 1);
    drain(50);

    // Single CPU read with two stall cycles, then owner drop and re-arbitration.
    fixed_addr[0] = 32'h100; iss_left[0] = 1; stall_force = 2;
    step(); check("single_c0_owner", arb_owner, 0); check("single_c0_stall", rs_stall[0], 1);
    step(); check("single_c1_owner", arb_owner, 1); check("single_c1_addr", {mem_cen, mem_addr}, {1'b1, 32'h100});
    check("single_c1_stall", rs_stall[0], 1);
    step(); check("single_c2_stall", rs_stall[0], 1);
    step(); check("single_c3_done", {rs_stall[0], rs_rdata[0]}, {1'b0, 32'hDEAD_BEEF});
    step(); check("drop_c4_owner", arb_owner, 1);
    iss_left[0] = 1;
    step(); check("drop_c5_idle", arb_owner, 0);
    step(); check("drop_c6_owner", arb_owner, 1);
    drain(50);

    // Later tie with the CPU as last owner goes to the COP.
    iss_left[0] = 1; iss_left[1] = 1;
    step(); check("tie2_c0", arb_owner, 0);
    step(); check("tie2_c1", arb_owner, 2);
    drain(50);

    // COP stalled for 5 cycles while the CPU waits; completion carries an error.
    fixed_addr[1] = 32'h3C; iss_left[1] = 1; stall_force = 5;
    step();
    iss_left[0] = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("lock_owner", arb_owner, 2);
      check("lock_req", {mem_cen, mem_wen, mem_addr}, {1'b1, 1'b0, 32'h3C});
      check("lock_cpu_stall", rs_stall[0], 1);
    end
    step();
    check("lock_done", {rs_stall[1], rs_error[1], rs_error[0]}, {1'b0, 1'b1, 1'b0});
    drain(50);

    // Reset while the COP read is stalled downstream.
    fixed_addr[1] = 32'h200; iss_left[1] = 1; stall_force = 100;
    step(); step();
    check("rst_pre_owner", arb_owner, 2);
    g_rst = 1'b1;
    #1;
    check("rst_mid_mem", {mem_cen, arb_owner}, 3'b000);
    check("rst_mid_stall", {rs_stall[0], rs_stall[1]}, 2'b11);
    cpu_q.delete(); cop_q.delete();
    for (int r = 0; r < 2; r++) begin
      active[r] = 1'b0; rq_cen[r] = 1'b0; iss_left[r] = 0; retired[r] = done_cnt[r];
    end
    stall_force = 0;
    mem_stall = 1'b0;
    @(posedge g_clk); @(posedge g_clk);
    #1 g_rst = 1'b0;

    // Sustained contention: grants alternate every BURST completions with no bubble.
    base = log_who.size();
    iss_left[0] = 2 * BURST; iss_left[1] = BURST;
    n = 0;
    while (log_who.size() < base + 3 * BURST && n < 200) begin
      step();
      n++;
    end
    check("burst_count", log_who.size() >= base + 3 * BURST, 1);
    if (log_who.size() >= base + 3 * BURST) begin
      for (int i = 0; i < 3 * BURST; i++)
        check("burst_who", log_who[base + i], ((i / BURST) % 2 == 0) ? 1 : 2);
      check("burst_no_bubble", log_cyc[base + 3 * BURST - 1] - log_cyc[base], 3 * BURST - 1);
    end
    drain(100);

    // Randomized traffic with random downstream stalls.
    stall_pct = 30;
    iss_left[0] = 100000; iss_left[1] = 100000;
    for (int ph = 0; ph < 6; ph++) begin
      iss_pct[0] = $urandom_range(20, 100);
      iss_pct[1] = $urandom_range(20, 100);
      repeat (500) step();
    end
    iss_left[0] = 0; iss_left[1] = 0;
    drain(400);
    check("queues_empty", {cpu_q.size(), cop_q.size()}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
